// File: rtl/inst_fetch_pkg.sv
// Shared constants for the instruction fetch slice.
// Latency: n/a (constants only).
// Backpressure: n/a.
package inst_fetch_pkg;

  localparam int          INST_W       = 32;
  localparam logic [31:0] NOP_INST     = 32'h0000_0000;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam int          PC_INC       = 4;
  localparam int          BUF_DEPTH    = 2;

endpackage

// File: rtl/inst_fetch_if.sv
// Bundles the ROM request port, the redirect input and the IF/ID valid/ready port.
// Latency: n/a (wires only).
// Backpressure: id_ready from decode; the ROM answers combinationally and never stalls.
// master = fetch side (drives rom_ce/rom_addr/id_*), slave = ROM + decode + branch unit side.
interface inst_fetch_if #(
  parameter int ADDR_W = 6,
  parameter int PC_W   = 32
);
  import inst_fetch_pkg::*;

  logic              rom_ce;
  logic [ADDR_W-1:0] rom_addr;
  logic [INST_W-1:0] rom_inst;
  logic              redirect_en;
  logic [PC_W-1:0]   redirect_pc;
  logic              id_valid;
  logic              id_ready;
  logic [PC_W-1:0]   id_pc;
  logic [INST_W-1:0] id_inst;

  modport master (
    output rom_ce, rom_addr, id_valid, id_pc, id_inst,
    input  rom_inst, redirect_en, redirect_pc, id_ready
  );

  modport slave (
    input  rom_ce, rom_addr, id_valid, id_pc, id_inst,
    output rom_inst, redirect_en, redirect_pc, id_ready
  );

endinterface

// File: rtl/inst_fetch_fetch_buf.sv
// 2-entry {pc, inst} FIFO between the ROM response and decode; head is entry 0.
// Latency: a pushed word reaches the head on the edge after the push when the FIFO was empty.
// Backpressure: caller must not push when count==2; flush wins over push and pop.
// Ports: clk, rst | push, push_pc, push_inst | pop, flush | head_pc, head_inst, count.
module fetch_buf
  import inst_fetch_pkg::*;
#(
  parameter int PC_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [PC_W-1:0]   push_pc,
  input  logic [INST_W-1:0] push_inst,
  input  logic              pop,
  input  logic              flush,
  output logic [PC_W-1:0]   head_pc,
  output logic [INST_W-1:0] head_inst,
  output logic [1:0]        count
);

  logic [PC_W-1:0]   pc0_q, pc0_d, pc1_q, pc1_d;
  logic [INST_W-1:0] inst0_q, inst0_d, inst1_q, inst1_d;
  logic [1:0]        count_q, count_d;

  always_comb begin
    pc0_d   = pc0_q;
    pc1_d   = pc1_q;
    inst0_d = inst0_q;
    inst1_d = inst1_q;
    count_d = count_q;
    if (flush) begin
      count_d = '0;
    end else if (push && pop) begin
      // Count stays put; the new word lands behind whatever remains.
      if (count_q == 2'd1) begin
        pc0_d   = push_pc;
        inst0_d = push_inst;
      end else if (count_q == 2'd2) begin
        pc0_d   = pc1_q;
        inst0_d = inst1_q;
        pc1_d   = push_pc;
        inst1_d = push_inst;
      end
    end else if (push && (count_q < 2'(BUF_DEPTH))) begin
      if (count_q == 2'd0) begin
        pc0_d   = push_pc;
        inst0_d = push_inst;
      end else begin
        pc1_d   = push_pc;
        inst1_d = push_inst;
      end
      count_d = count_q + 2'd1;
    end else if (pop && (count_q != 2'd0)) begin
      // Popping the last word leaves entry 0 untouched so id_* holds its last value.
      if (count_q == 2'd2) begin
        pc0_d   = pc1_q;
        inst0_d = inst1_q;
      end
      count_d = count_q - 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc0_q   <= '0;
      pc1_q   <= '0;
      inst0_q <= NOP_INST;
      inst1_q <= NOP_INST;
      count_q <= '0;
    end else begin
      pc0_q   <= pc0_d;
      pc1_q   <= pc1_d;
      inst0_q <= inst0_d;
      inst1_q <= inst1_d;
      count_q <= count_d;
    end
  end

  assign head_pc   = pc0_q;
  assign head_inst = inst0_q;
  assign count     = count_q;

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch: owns the PC, reads the ROM and hands {pc, inst} to decode.
// Latency: ROM word appears on id_* one edge after its address is presented; redirect target after 2 edges.
// Backpressure: id_ready low fills the 2-entry buffer, then the PC freezes until space frees.
// Ports: clk, rst (sync, active-high) | bus (master): rom_ce/rom_addr/rom_inst, redirect_en/redirect_pc,
//        id_valid/id_ready/id_pc/id_inst.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter int              ADDR_W   = 6,
  parameter int              PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = PC_W'(RESET_PC_DEF)
) (
  input  logic          clk,
  input  logic          rst,
  inst_fetch_if.master  bus
);

  logic              rom_ce_q, rom_ce_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [1:0]        buf_count;
  logic [PC_W-1:0]   buf_pc;
  logic [INST_W-1:0] buf_inst;
  logic              id_valid;
  logic              fetch_fire;
  logic              pop;

  assign id_valid   = (buf_count != 2'd0);
  assign pop        = id_valid & bus.id_ready;
  // A redirect cycle never fetches: the address on the ROM belongs to the abandoned path.
  assign fetch_fire = rom_ce_q & ~bus.redirect_en & (buf_count < 2'(BUF_DEPTH));

  always_comb begin
    rom_ce_d = 1'b1;
    pc_d     = pc_q;
    if (bus.redirect_en) begin
      pc_d = bus.redirect_pc & ~PC_W'(3);
    end else if (fetch_fire) begin
      pc_d = pc_q + PC_W'(PC_INC);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rom_ce_q <= 1'b0;
      pc_q     <= RESET_PC;
    end else begin
      rom_ce_q <= rom_ce_d;
      pc_q     <= pc_d;
    end
  end

  fetch_buf #(
    .PC_W (PC_W)
  ) u_fetch_buf (
    .clk       (clk),
    .rst       (rst),
    .push      (fetch_fire),
    .push_pc   (pc_q),
    .push_inst (bus.rom_inst),
    .pop       (pop),
    .flush     (bus.redirect_en),
    .head_pc   (buf_pc),
    .head_inst (buf_inst),
    .count     (buf_count)
  );

  assign bus.rom_ce   = rom_ce_q;
  assign bus.rom_addr = pc_q[ADDR_W+1:2];
  assign bus.id_valid = id_valid;
  assign bus.id_pc    = buf_pc;
  assign bus.id_inst  = buf_inst;

endmodule

// File: tb/tb_inst_fetch.sv
// Testbench for inst_fetch: ROM model word n = 0x1000_0000 + n, stream scoreboard for decode.
// Latency: n/a.
// Backpressure: id_ready driven by the scenario tasks (fixed patterns and random).
module tb_inst_fetch;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  inst_fetch_if #(.ADDR_W(6), .PC_W(32)) bus ();

  assign bus.rom_inst = 32'h1000_0000 + {26'h0, bus.rom_addr};

  inst_fetch #(.ADDR_W(6), .PC_W(32), .RESET_PC(32'h0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          checks = 0;
  int          passed = 0;
  int          accepts = 0;
  logic [31:0] exp_pc = 32'h0;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_pc, prev_inst;

  function automatic logic [31:0] rom_word(input logic [31:0] pc);
    return 32'h1000_0000 + ((pc >> 2) & 32'h3F);
  endfunction

  // Apply inputs for the coming edge, score the decode handshake, advance to the next negedge.
  task automatic tick(input logic rdy, input logic ren, input logic [31:0] rpc);
    bus.id_ready    = rdy;
    bus.redirect_en = ren;
    bus.redirect_pc = rpc;
    #1;
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        checks++;
        if (bus.id_valid !== 1'b1 || bus.id_pc !== prev_pc || bus.id_inst !== prev_inst)
          $display("FAIL hold: got v=%0b pc=%h inst=%h, want v=1 pc=%h inst=%h",
                   bus.id_valid, bus.id_pc, bus.id_inst, prev_pc, prev_inst);
        else passed++;
      end
      if (bus.id_valid === 1'b1 && rdy) begin
        accepts++;
        checks++;
        if (bus.id_pc !== exp_pc || bus.id_inst !== rom_word(exp_pc))
          $display("FAIL stream: got pc=%h inst=%h, want pc=%h inst=%h",
                   bus.id_pc, bus.id_inst, exp_pc, rom_word(exp_pc));
        else passed++;
        exp_pc = exp_pc + 32'd4;
      end
      prev_stall = (bus.id_valid === 1'b1) && !rdy && !ren;
      prev_pc    = bus.id_pc;
      prev_inst  = bus.id_inst;
      if (ren) exp_pc = {rpc[31:2], 2'b00};
    end
    @(negedge clk);
  endtask

  // Checks the two cycles after reset release: rom_ce rises, then word 0 appears.
  task automatic check_startup(input string tag);
    checks++;
    if (bus.rom_ce !== 1'b0 || bus.id_valid !== 1'b0 || bus.rom_addr !== 6'h00)
      $display("FAIL %s_rst_state: got ce=%0b v=%0b addr=%h, want ce=0 v=0 addr=00",
               tag, bus.rom_ce, bus.id_valid, bus.rom_addr);
    else passed++;
    tick(1'b1, 1'b0, 32'h0);
    checks++;
    if (bus.rom_ce !== 1'b1 || bus.id_valid !== 1'b0)
      $display("FAIL %s_ce_rise: got ce=%0b v=%0b, want ce=1 v=0", tag, bus.rom_ce, bus.id_valid);
    else passed++;
    tick(1'b1, 1'b0, 32'h0);
    checks++;
    if (bus.id_valid !== 1'b1 || bus.id_pc !== 32'h0 || bus.id_inst !== 32'h1000_0000)
      $display("FAIL %s_first_word: got v=%0b pc=%h inst=%h, want v=1 pc=0 inst=10000000",
               tag, bus.id_valid, bus.id_pc, bus.id_inst);
    else passed++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(1'b0, 1'b0, 32'h0);
    tick(1'b0, 1'b0, 32'h0);
    rst    = 1'b0;
    exp_pc = 32'h0;
    checks++;
    if (bus.id_pc !== 32'h0 || bus.id_inst !== 32'h0)
      $display("FAIL reset_id: got pc=%h inst=%h, want 0/0", bus.id_pc, bus.id_inst);
    else passed++;
    check_startup("reset");
  endtask

  task automatic test_stream();
    for (int i = 0; i < 16; i++) begin
      tick(1'b1, 1'b0, 32'h0);
      checks++;
      if (bus.id_valid !== 1'b1)
        $display("FAIL stream_gap: cycle %0d got v=%0b, want 1", i, bus.id_valid);
      else passed++;
    end
  endtask

  task automatic test_stall();
    logic [5:0] frozen;
    tick(1'b0, 1'b0, 32'h0);
    frozen = bus.rom_addr;
    for (int i = 0; i < 4; i++) begin
      tick(1'b0, 1'b0, 32'h0);
      checks++;
      if (bus.rom_addr !== frozen || bus.id_valid !== 1'b1)
        $display("FAIL stall_freeze: got addr=%h v=%0b, want addr=%h v=1", bus.rom_addr, bus.id_valid, frozen);
      else passed++;
    end
    for (int i = 0; i < 6; i++) tick(1'b1, 1'b0, 32'h0);
  endtask

  task automatic test_redirect();
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 32'h0);
    tick(1'b0, 1'b1, 32'h0000_0043);
    checks++;
    if (bus.id_valid !== 1'b0 || bus.rom_addr !== 6'h10)
      $display("FAIL redir_flush: got v=%0b addr=%h, want v=0 addr=10", bus.id_valid, bus.rom_addr);
    else passed++;
    tick(1'b0, 1'b0, 32'h0);
    checks++;
    if (bus.id_valid !== 1'b1 || bus.id_pc !== 32'h40 || bus.id_inst !== 32'h1000_0010)
      $display("FAIL redir_first: got v=%0b pc=%h inst=%h, want v=1 pc=40 inst=10000010",
               bus.id_valid, bus.id_pc, bus.id_inst);
    else passed++;
    tick(1'b1, 1'b0, 32'h0);
    checks++;
    if (bus.id_pc !== 32'h44 || bus.id_inst !== 32'h1000_0011)
      $display("FAIL redir_second: got pc=%h inst=%h, want pc=44 inst=10000011", bus.id_pc, bus.id_inst);
    else passed++;
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 32'h0);
  endtask

  task automatic test_back_to_back();
    tick(1'b1, 1'b1, 32'h20);
    checks++;
    if (bus.id_valid !== 1'b0)
      $display("FAIL b2b_first_flush: got v=%0b, want 0", bus.id_valid);
    else passed++;
    tick(1'b1, 1'b1, 32'h80);
    checks++;
    if (bus.id_valid !== 1'b0 || bus.rom_addr !== 6'h20)
      $display("FAIL b2b_second: got v=%0b addr=%h, want v=0 addr=20", bus.id_valid, bus.rom_addr);
    else passed++;
    tick(1'b1, 1'b0, 32'h0);
    checks++;
    if (bus.id_valid !== 1'b1 || bus.id_pc !== 32'h80)
      $display("FAIL b2b_target: got v=%0b pc=%h, want v=1 pc=80", bus.id_valid, bus.id_pc);
    else passed++;
    for (int i = 0; i < 4; i++) tick(1'b1, 1'b0, 32'h0);
  endtask

  task automatic test_wrap();
    logic [5:0] want_addr [4];
    want_addr = '{6'h3E, 6'h3F, 6'h00, 6'h01};
    tick(1'b1, 1'b1, 32'hF8);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (bus.rom_addr !== want_addr[i])
        $display("FAIL wrap_addr%0d: got %h, want %h", i, bus.rom_addr, want_addr[i]);
      else passed++;
      tick(1'b1, 1'b0, 32'h0);
    end
    for (int i = 0; i < 4; i++) tick(1'b1, 1'b0, 32'h0);
  endtask

  task automatic test_mid_reset();
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 32'h0);
    rst = 1'b1;
    tick(1'b0, 1'b0, 32'h0);
    rst    = 1'b0;
    exp_pc = 32'h0;
    check_startup("midrst");
    for (int i = 0; i < 6; i++) tick(1'b1, 1'b0, 32'h0);
  endtask

  task automatic test_random();
    int start_acc;
    start_acc = accepts;
    for (int i = 0; i < 400; i++) begin
      tick($urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0, $urandom & 32'h3FF);
    end
    checks++;
    if (accepts - start_acc < 150)
      $display("FAIL random_progress: got %0d accepts, want >= 150", accepts - start_acc);
    else passed++;
  endtask

  initial begin
    bus.id_ready    = 1'b0;
    bus.redirect_en = 1'b0;
    bus.redirect_pc = 32'h0;
    @(negedge clk);
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_back_to_back();
    test_wrap();
    test_mid_reset();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
